// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer with optional parity and 1/2 stop bits
//
// Captures tx_Data on the single-cycle tx_Start pulse and shifts it out LSB
// first as start bit, 8 data bits, optional parity bit and STOP_BITS stop bits.
// Every bit lasts CLKS_PER_BIT cycles of sample_Clk.
//
// Ports:
//   sample_Clk  in   1  clock, rising edge
//   reset       in   1  asynchronous, active-high reset
//   tx_Start    in   1  one-cycle send request (ignored while busy)
//   tx_Data     in   8  byte to send, sampled with tx_Start
//   tx_Serial   out  1  registered serial line, idles high
//   tx_Busy     out  1  high while a frame is on the line
//   tx_Done     out  1  one-cycle pulse when the last stop bit ends

module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       sample_Clk,
  input  logic       reset,
  input  logic       tx_Start,
  input  logic [7:0] tx_Data,
  output logic       tx_Serial,
  output logic       tx_Busy,
  output logic       tx_Done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic PAR_ODD   = 1'(PARITY_ODD);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  generate
    if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
      $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2 and STOP_BITS must be 1 or 2");
    end
  endgenerate

  logic [2:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q,  baud_d;
  logic [2:0]        bit_q,   bit_d;
  logic              stop_q,  stop_d;
  logic [7:0]        data_q,  data_d;
  logic              serial_q, serial_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  logic baud_last;
  assign baud_last = (baud_q == BAUD_LAST);

  // tx_Serial is registered, so serial_d is the level of the bit that the
  // next state will drive; each transition loads the first cycle of the new bit.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    data_d   = data_q;
    serial_d = serial_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        serial_d = 1'b1;
        busy_d   = 1'b0;
        if (tx_Start) begin
          data_d   = tx_Data;
          baud_d   = '0;
          bit_d    = '0;
          stop_d   = 1'b0;
          state_d  = ST_START;
          serial_d = 1'b0;
          busy_d   = 1'b1;
        end
      end

      ST_START: begin
        if (baud_last) begin
          baud_d   = '0;
          bit_d    = '0;
          state_d  = ST_DATA;
          serial_d = data_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_d  = ST_PARITY;
              serial_d = (^data_q) ^ PAR_ODD;
            end else begin
              state_d  = ST_STOP;
              serial_d = 1'b1;
            end
          end else begin
            bit_d    = bit_q + 3'd1;
            serial_d = data_q[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_PARITY: begin
        if (baud_last) begin
          baud_d   = '0;
          state_d  = ST_STOP;
          serial_d = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_STOP: begin
        serial_d = 1'b1;
        if (baud_last) begin
          baud_d = '0;
          if (stop_q == STOP_LAST) begin
            // Back in IDLE during the tx_Done cycle, so a tx_Start arriving
            // with the pulse is accepted and frames run back to back.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        serial_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sample_Clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      data_q   <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      data_q   <= data_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx_Serial = serial_q;
  assign tx_Busy   = busy_q;
  assign tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - scoreboard bench for uart_tx_serializer across four parameter sets

module tb_uart_tx_serializer;

  // u0: no parity, 1 stop; u1: even parity; u2: odd parity; u3: 2 stop bits
  typedef struct packed {
    logic [11:0] bits;
    logic [3:0]  nbits;
  } frame_t;

  logic       clk = 1'b0;
  logic [3:0] rst = 4'hF;
  logic [3:0] start = 4'h0;
  logic [3:0] serial, busy, done;
  logic [3:0] mon_en = 4'hF;
  logic [7:0] data [4];

  frame_t sb [4][$];

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  function automatic int pe(input int i);
    return (i == 1 || i == 2) ? 1 : 0;
  endfunction

  function automatic int stops(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g
    uart_tx_serializer #(
      .CLKS_PER_BIT(4),
      .PARITY_EN   ((gi == 1 || gi == 2) ? 1 : 0),
      .PARITY_ODD  ((gi == 2) ? 1 : 0),
      .STOP_BITS   ((gi == 3) ? 2 : 1)
    ) u_dut (
      .sample_Clk(clk),
      .reset     (rst[gi]),
      .tx_Start  (start[gi]),
      .tx_Data   (data[gi]),
      .tx_Serial (serial[gi]),
      .tx_Busy   (busy[gi]),
      .tx_Done   (done[gi])
    );

    initial begin : mon
      frame_t f;
      logic   ok;
      forever begin
        @(negedge clk);
        if (mon_en[gi] && serial[gi] === 1'b0) begin
          if (sb[gi].size() == 0) begin
            chk($sformatf("u%0d_unexpected_frame", gi), 32'd1, 32'd0);
            while (busy[gi] !== 1'b0) @(negedge clk);
          end else begin
            f = sb[gi].pop_front();
            for (int b = 0; b < int'(f.nbits); b++) begin
              ok = 1'b1;
              for (int c = 0; c < 4; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (serial[gi] !== f.bits[b] || busy[gi] !== 1'b1 || done[gi] !== 1'b0) ok = 1'b0;
              end
              chk($sformatf("u%0d_bit%0d_level%0d_busy_nodone", gi, b, f.bits[b]), {31'd0, ok}, 32'd1);
            end
            @(negedge clk);
            chk($sformatf("u%0d_end_busy_done", gi), {30'd0, busy[gi], done[gi]}, 32'h1);
          end
        end
      end
    end
  end

  task automatic send(input int i, input logic [7:0] d, input logic par, input bit push);
    frame_t f;
    int n;
    f.bits = '0;
    f.bits[0] = 1'b0;
    f.bits[8:1] = d;
    n = 9;
    if (pe(i) != 0) begin
      f.bits[n] = par;
      n++;
    end
    for (int s = 0; s < stops(i); s++) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.nbits = 4'(n);
    if (push) sb[i].push_back(f);
    data[i]  = d;
    start[i] = 1'b1;
    @(posedge clk);
    #1 start[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int  t;
    bit  idle;
    for (t = 0; t < 1000; t++) begin
      @(negedge clk);
      idle = 1'b1;
      for (int i = 0; i < 4; i++)
        if (sb[i].size() != 0 || busy[i] !== 1'b0) idle = 1'b0;
      if (idle) break;
    end
    chk("drain_before_timeout", {31'd0, (t < 1000)}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int  t;
    bit  bad;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;

    // Case 1: reset, idle, reset again mid-cycle, release
    repeat (3) @(posedge clk);
    #1 rst = 4'h0;
    repeat (3) @(posedge clk);
    #3 rst = 4'hF;
    @(posedge clk);
    #3 rst = 4'h0;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("u%0d_reset_serial_busy_done", i), {29'd0, serial[i], busy[i], done[i]}, 32'h4);

    // Case 2: 0xA5, no parity, 1 stop (40-cycle frame)
    @(posedge clk);
    #1 send(0, 8'hA5, 1'b0, 1'b1);
    wait_idle();

    // Case 3: parity variants (even 0xA5 -> 0, odd 0xA5 -> 1, even 0x07 -> 1, odd 0x00 -> 1)
    @(posedge clk);
    #1;
    send(1, 8'hA5, 1'b0, 1'b1);
    send(2, 8'hA5, 1'b1, 1'b1);
    wait_idle();
    @(posedge clk);
    #1;
    send(1, 8'h07, 1'b1, 1'b1);
    send(2, 8'h00, 1'b1, 1'b1);
    wait_idle();

    // Case 4: 0x3C request in cycle 10 of a 0xA5 frame must be ignored
    @(posedge clk);
    #1 send(0, 8'hA5, 1'b0, 1'b1);
    repeat (9) @(posedge clk);
    #1 send(0, 8'h3C, 1'b0, 1'b0);
    wait_idle();

    // Case 5: 0xFF with 2 stop bits, then 0x01 requested in its tx_Done cycle
    @(posedge clk);
    #1 send(3, 8'hFF, 1'b0, 1'b1);
    for (t = 0; t < 200 && done[3] !== 1'b1; t++) @(negedge clk);
    chk("u3_done_seen", {31'd0, done[3]}, 32'd1);
    send(3, 8'h01, 1'b0, 1'b1);
    @(negedge clk);
    chk("u3_back_to_back_start", {31'd0, serial[3]}, 32'd0);
    wait_idle();

    // Case 6: reset during DATA bit 3, no tx_Done, then a clean 0x55 frame
    mon_en[0] = 1'b0;
    @(posedge clk);
    #1 send(0, 8'hA5, 1'b0, 1'b0);
    repeat (17) @(posedge clk);
    #1 chk("u0_pre_reset_bit3", {31'd0, serial[0]}, 32'd0);
    #1 rst[0] = 1'b1;
    #1 chk("u0_async_reset_serial_busy_done", {29'd0, serial[0], busy[0], done[0]}, 32'h4);
    @(posedge clk);
    #1 rst[0] = 1'b0;
    bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done[0] !== 1'b0 || serial[0] !== 1'b1 || busy[0] !== 1'b0) bad = 1'b1;
    end
    chk("u0_abandoned_frame_quiet", {31'd0, bad}, 32'd0);
    mon_en[0] = 1'b1;
    @(posedge clk);
    #1 send(0, 8'h55, 1'b0, 1'b1);
    wait_idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
